// File: rtl/spw_tx_char_scheduler.sv
// SpaceWire transmit character scheduler: chooses the next character at each
// boundary, tracks credit, and drives state/bit-slot/history to the bit datapath.
module spw_tx_char_scheduler #(
    parameter int MAX_CREDIT = 56
) (
    input  logic       pclk_tx,
    input  logic       reset_tx,
    input  logic       tx_bit_tick,
    input  logic       tx_link_enable,
    input  logic       send_fct_tx,
    input  logic       send_data_tx,
    input  logic       gotfct_tx,
    input  logic       fct_req,
    output logic       fct_ack,
    input  logic       tickin_tx,
    input  logic [7:0] timecode_in,
    input  logic       txwrite_tx,
    input  logic [8:0] txdata_in,
    output logic       txready,
    output logic [6:0] state_tx_data,
    output logic [9:0] global_counter_transfer_data,
    output logic [3:0] bit_index,
    output logic [8:0] tx_data_out,
    output logic [7:0] timecode_out,
    output logic [5:0] last_type_data,
    output logic       txdata_flagctrl_tx_last,
    output logic       last_timein_control_flag_tx,
    output logic [5:0] credit,
    output logic       credit_error
);
    localparam logic [6:0] ST_START  = 7'b0000000;
    localparam logic [6:0] ST_NULL   = 7'b0000001;
    localparam logic [6:0] ST_FCT    = 7'b0000010;
    localparam logic [6:0] ST_NULL_C = 7'b0000100;
    localparam logic [6:0] ST_FCT_C  = 7'b0001000;
    localparam logic [6:0] ST_DATA_C = 7'b0010000;
    localparam logic [6:0] ST_TIME_C = 7'b1000000;

    localparam logic [5:0] TY_NULL  = 6'b000001;
    localparam logic [5:0] TY_FCT   = 6'b000010;
    localparam logic [5:0] TY_EOP   = 6'b000100;
    localparam logic [5:0] TY_EEP   = 6'b001000;
    localparam logic [5:0] TY_DATA  = 6'b010000;
    localparam logic [5:0] TY_TIMEC = 6'b100000;

    logic [6:0] state_q, state_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] credit_q, credit_d;
    logic       hold_valid_q, hold_valid_d;
    logic [8:0] hold_q, hold_d;
    logic       tc_pend_q, tc_pend_d;
    logic [7:0] tc_val_q, tc_val_d;
    logic [8:0] tx_data_q, tx_data_d;
    logic [7:0] timecode_q, timecode_d;
    logic [5:0] last_type_q, last_type_d;
    logic       par_data_q, par_data_d;
    logic       par_tc_q, par_tc_d;
    logic       fct_ack_q, fct_ack_d;
    logic       cerr_q, cerr_d;

    logic [3:0] last_slot;
    logic [5:0] fin_type;
    logic       at_end, sel_tc, sel_fct, sel_data;
    logic [6:0] credit_dec, credit_sum;

    // State register; link disable behaves exactly like reset.
    always_ff @(posedge pclk_tx) begin
        if (reset_tx || !tx_link_enable) begin
            state_q      <= ST_START;
            bit_q        <= '0;
            credit_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            tc_pend_q    <= 1'b0;
            tc_val_q     <= '0;
            tx_data_q    <= '0;
            timecode_q   <= '0;
            last_type_q  <= TY_NULL;
            par_data_q   <= 1'b0;
            par_tc_q     <= 1'b0;
            fct_ack_q    <= 1'b0;
            cerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            credit_q     <= credit_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            tc_pend_q    <= tc_pend_d;
            tc_val_q     <= tc_val_d;
            tx_data_q    <= tx_data_d;
            timecode_q   <= timecode_d;
            last_type_q  <= last_type_d;
            par_data_q   <= par_data_d;
            par_tc_q     <= par_tc_d;
            fct_ack_q    <= fct_ack_d;
            cerr_q       <= cerr_d;
        end
    end

    // Last bit slot and type of the character currently on the wire.
    always_comb begin
        last_slot = 4'd7;
        fin_type  = TY_NULL;
        case (state_q)
            ST_FCT, ST_FCT_C: begin
                last_slot = 4'd3;
                fin_type  = TY_FCT;
            end
            ST_DATA_C: begin
                last_slot = tx_data_q[8] ? 4'd3 : 4'd9;
                fin_type  = !tx_data_q[8] ? TY_DATA : (tx_data_q[0] ? TY_EEP : TY_EOP);
            end
            ST_TIME_C: begin
                last_slot = 4'd13;
                fin_type  = TY_TIMEC;
            end
            default: ;
        endcase
    end

    assign at_end   = tx_bit_tick && (state_q != ST_START) && (bit_q == last_slot);
    assign sel_tc   = tc_pend_q && send_data_tx;
    assign sel_fct  = !sel_tc && fct_req && send_fct_tx;
    assign sel_data = !sel_tc && !sel_fct && hold_valid_q && send_data_tx && (credit_q != 6'd0);

    assign credit_dec = {1'b0, credit_q} - {6'd0, at_end && sel_data};
    assign credit_sum = credit_dec + 7'd8;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        credit_d     = credit_dec[5:0];
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        tc_pend_d    = tc_pend_q;
        tc_val_d     = tc_val_q;
        tx_data_d    = tx_data_q;
        timecode_d   = timecode_q;
        last_type_d  = last_type_q;
        par_data_d   = par_data_q;
        par_tc_d     = par_tc_q;
        fct_ack_d    = 1'b0;
        cerr_d       = 1'b0;

        if (state_q == ST_START) begin
            state_d = ST_NULL;
            bit_d   = '0;
        end else if (at_end) begin
            bit_d       = '0;
            last_type_d = fin_type;
            if (state_q == ST_DATA_C && !tx_data_q[8])
                par_data_d = ^tx_data_q[7:0];
            if (state_q == ST_TIME_C)
                par_tc_d = ^timecode_q;
            if (sel_tc) begin
                state_d    = ST_TIME_C;
                timecode_d = tc_val_q;
                tc_pend_d  = 1'b0;
            end else if (sel_fct) begin
                state_d   = send_data_tx ? ST_FCT_C : ST_FCT;
                fct_ack_d = 1'b1;
            end else if (sel_data) begin
                state_d      = ST_DATA_C;
                tx_data_d    = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                state_d = send_data_tx ? ST_NULL_C : ST_NULL;
            end
        end else if (tx_bit_tick) begin
            bit_d = bit_q + 4'd1;
        end

        // A write is only accepted into an empty holder, so it never races a data start.
        if (txwrite_tx && txready) begin
            hold_valid_d = 1'b1;
            hold_d       = txdata_in;
        end
        if (tickin_tx) begin
            tc_pend_d = 1'b1;
            tc_val_d  = timecode_in;
        end
        if (gotfct_tx) begin
            if (credit_sum > 7'(MAX_CREDIT))
                cerr_d = 1'b1;
            else
                credit_d = credit_sum[5:0];
        end
    end

    // Output decode.
    always_comb begin
        global_counter_transfer_data = '0;
        if (state_q != ST_START && bit_q < 4'd10)
            global_counter_transfer_data = 10'd1 << bit_q;
    end

    assign txready                     = tx_link_enable && (state_q != ST_START) && !hold_valid_q;
    assign state_tx_data               = state_q;
    assign bit_index                   = bit_q;
    assign tx_data_out                 = tx_data_q;
    assign timecode_out                = timecode_q;
    assign last_type_data              = last_type_q;
    assign txdata_flagctrl_tx_last     = par_data_q;
    assign last_timein_control_flag_tx = par_tc_q;
    assign credit                      = credit_q;
    assign credit_error                = cerr_q;
    assign fct_ack                     = fct_ack_q;
endmodule

// File: tb/tb_spw_tx_char_scheduler.sv
// Directed bench for spw_tx_char_scheduler: a per-cycle vector table for the
// NULL/FCT sequencing plus hand-written credit, data, time-code and link-drop sequences.
module tb_spw_tx_char_scheduler;
    logic       clk = 1'b0;
    logic       reset_tx = 1'b0, tx_bit_tick = 1'b0, tx_link_enable = 1'b0;
    logic       send_fct_tx = 1'b0, send_data_tx = 1'b0, gotfct_tx = 1'b0, fct_req = 1'b0;
    logic       tickin_tx = 1'b0, txwrite_tx = 1'b0;
    logic [7:0] timecode_in = '0;
    logic [8:0] txdata_in = '0;
    logic       fct_ack, txready, txdata_flagctrl_tx_last, last_timein_control_flag_tx, credit_error;
    logic [6:0] state_tx_data;
    logic [9:0] global_counter_transfer_data;
    logic [3:0] bit_index;
    logic [8:0] tx_data_out;
    logic [7:0] timecode_out;
    logic [5:0] last_type_data, credit;

    int errors = 0;
    int checks = 0;

    spw_tx_char_scheduler #(.MAX_CREDIT(56)) dut (
        .pclk_tx(clk), .reset_tx(reset_tx), .tx_bit_tick(tx_bit_tick),
        .tx_link_enable(tx_link_enable), .send_fct_tx(send_fct_tx), .send_data_tx(send_data_tx),
        .gotfct_tx(gotfct_tx), .fct_req(fct_req), .fct_ack(fct_ack),
        .tickin_tx(tickin_tx), .timecode_in(timecode_in),
        .txwrite_tx(txwrite_tx), .txdata_in(txdata_in), .txready(txready),
        .state_tx_data(state_tx_data), .global_counter_transfer_data(global_counter_transfer_data),
        .bit_index(bit_index), .tx_data_out(tx_data_out), .timecode_out(timecode_out),
        .last_type_data(last_type_data), .txdata_flagctrl_tx_last(txdata_flagctrl_tx_last),
        .last_timein_control_flag_tx(last_timein_control_flag_tx),
        .credit(credit), .credit_error(credit_error)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_START = 7'b0000000, S_NULL = 7'b0000001, S_FCT = 7'b0000010;
    localparam logic [6:0] S_NULLC = 7'b0000100, S_FCTC = 7'b0001000, S_DATA = 7'b0010000;
    localparam logic [6:0] S_TIME = 7'b1000000;
    localparam logic [5:0] T_NULL = 6'b000001, T_FCT = 6'b000010, T_EOP = 6'b000100;
    localparam logic [5:0] T_DATA = 6'b010000, T_TIMEC = 6'b100000;

    typedef struct {
        logic       rst, en, sfct, sdata, tick, freq;
        logic [6:0] st;
        logic [3:0] bi;
        logic       rdy, ack;
        logic [5:0] ty;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic sfct, input logic sdata,
                       input logic tick, input logic freq, input logic [6:0] st,
                       input logic [3:0] bi, input logic rdy, input logic ack, input logic [5:0] ty);
        vec_t v;
        v = '{rst, en, sfct, sdata, tick, freq, st, bi, rdy, ack, ty};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tx_bit_tick = 1'b1;
            step();
            tx_bit_tick = 1'b0;
        end
    endtask

    task automatic write_word(input logic [8:0] w);
        txwrite_tx = 1'b1;
        txdata_in  = w;
        step();
        txwrite_tx = 1'b0;
    endtask

    task automatic fct_in();
        gotfct_tx = 1'b1;
        step();
        gotfct_tx = 1'b0;
    endtask

    task automatic tick_in(input logic [7:0] tc);
        tickin_tx   = 1'b1;
        timecode_in = tc;
        step();
        tickin_tx   = 1'b0;
    endtask

    task automatic do_reset();
        reset_tx       = 1'b1;
        tx_link_enable = 1'b1;
        send_fct_tx    = 1'b0;
        send_data_tx   = 1'b0;
        fct_req        = 1'b0;
        step();
        reset_tx = 1'b0;
        step();
    endtask

    initial begin
        logic [9:0] exp_g;

        // Per-cycle table: reset, start exit, one NULL, two FCTs, NULL, link drop.
        add(1, 1, 0, 0, 0, 0, S_START, 0, 0, 0, T_NULL);
        add(0, 1, 0, 0, 0, 0, S_NULL, 0, 1, 0, T_NULL);
        for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 0, S_NULL, 4'(i), 1, 0, T_NULL);
        add(0, 1, 1, 0, 1, 1, S_FCT, 0, 1, 1, T_NULL);
        for (int i = 1; i < 4; i++) add(0, 1, 1, 0, 1, 1, S_FCT, 4'(i), 1, 0, T_NULL);
        add(0, 1, 1, 0, 1, 1, S_FCT, 0, 1, 1, T_FCT);
        for (int i = 1; i < 4; i++) add(0, 1, 1, 0, 1, 0, S_FCT, 4'(i), 1, 0, T_FCT);
        add(0, 1, 1, 0, 1, 0, S_NULL, 0, 1, 0, T_FCT);
        add(0, 1, 1, 0, 1, 0, S_NULL, 1, 1, 0, T_FCT);
        add(0, 0, 0, 0, 0, 0, S_START, 0, 0, 0, T_NULL);

        for (int r = 0; r < vecs.size(); r++) begin
            reset_tx       = vecs[r].rst;
            tx_link_enable = vecs[r].en;
            send_fct_tx    = vecs[r].sfct;
            send_data_tx   = vecs[r].sdata;
            tx_bit_tick    = vecs[r].tick;
            fct_req        = vecs[r].freq;
            step();
            exp_g = (vecs[r].st != S_START && vecs[r].bi < 4'd10) ? (10'd1 << vecs[r].bi) : 10'd0;
            chk($sformatf("row%0d state", r), state_tx_data, vecs[r].st);
            chk($sformatf("row%0d bit_index", r), bit_index, vecs[r].bi);
            chk($sformatf("row%0d slot", r), global_counter_transfer_data, exp_g);
            chk($sformatf("row%0d txready", r), txready, vecs[r].rdy);
            chk($sformatf("row%0d fct_ack", r), fct_ack, vecs[r].ack);
            chk($sformatf("row%0d last_type", r), last_type_data, vecs[r].ty);
        end
        tx_bit_tick = 1'b0;

        // Data path: credit gating, data parity history, EOP.
        do_reset();
        send_data_tx = 1'b1;
        send_fct_tx  = 1'b1;
        chk("A start exit", state_tx_data, S_NULL);
        chk("A credit reset", credit, 0);
        write_word(9'h0A5);
        chk("A hold full", txready, 0);
        ticks(8);
        chk("A blocked by credit", state_tx_data, S_NULLC);
        fct_in();
        chk("A credit +8", credit, 8);
        ticks(8);
        chk("A data start", state_tx_data, S_DATA);
        chk("A data word", tx_data_out, 9'h0A5);
        chk("A credit dec", credit, 7);
        chk("A hold empty", txready, 1);
        write_word(9'h0A4);
        ticks(10);
        chk("A type data", last_type_data, T_DATA);
        chk("A parity A5", txdata_flagctrl_tx_last, 0);
        chk("A second word", tx_data_out, 9'h0A4);
        chk("A credit 6", credit, 6);
        ticks(10);
        chk("A parity A4", txdata_flagctrl_tx_last, 1);
        chk("A back to null_c", state_tx_data, S_NULLC);
        write_word(9'h100);
        ticks(8);
        chk("A eop start", state_tx_data, S_DATA);
        chk("A credit 5", credit, 5);
        ticks(4);
        chk("A type eop", last_type_data, T_EOP);
        chk("A parity kept", txdata_flagctrl_tx_last, 1);

        // Credit ceiling and overflow coincident with a data start.
        do_reset();
        for (int i = 0; i < 7; i++) fct_in();
        chk("B credit 56", credit, 56);
        chk("B no error", credit_error, 0);
        fct_in();
        chk("B overflow pulse", credit_error, 1);
        chk("B credit held", credit, 56);
        step();
        chk("B pulse ends", credit_error, 0);
        send_data_tx = 1'b1;
        write_word(9'h055);
        ticks(7);
        tx_bit_tick = 1'b1;
        gotfct_tx   = 1'b1;
        step();
        tx_bit_tick = 1'b0;
        gotfct_tx   = 1'b0;
        chk("B data start", state_tx_data, S_DATA);
        chk("B credit 55", credit, 55);
        chk("B overflow on start", credit_error, 1);

        // Time-code priority, 14-bit length, re-arm on the selecting edge.
        do_reset();
        send_data_tx = 1'b1;
        send_fct_tx  = 1'b1;
        fct_in();
        write_word(9'h011);
        fct_req = 1'b1;
        tick_in(8'h3C);
        ticks(8);
        chk("C tc wins", state_tx_data, S_TIME);
        chk("C tc value", timecode_out, 8'h3C);
        chk("C no fct ack", fct_ack, 0);
        ticks(9);
        chk("C slot 9", global_counter_transfer_data, 10'h200);
        ticks(1);
        chk("C bit 10", bit_index, 10);
        chk("C slot 10 zero", global_counter_transfer_data, 0);
        ticks(3);
        chk("C bit 13", bit_index, 13);
        chk("C still tc", state_tx_data, S_TIME);
        ticks(1);
        chk("C fct next", state_tx_data, S_FCTC);
        chk("C fct ack", fct_ack, 1);
        chk("C type timec", last_type_data, T_TIMEC);
        chk("C tc parity 3C", last_timein_control_flag_tx, 0);
        fct_req     = 1'b0;
        tx_bit_tick = 1'b1;
        tickin_tx   = 1'b1;
        timecode_in = 8'h3D;
        step();
        tickin_tx = 1'b0;
        ticks(2);
        tickin_tx   = 1'b1;
        timecode_in = 8'h55;
        tx_bit_tick = 1'b1;
        step();
        tickin_tx   = 1'b0;
        tx_bit_tick = 1'b0;
        chk("C tc again", state_tx_data, S_TIME);
        chk("C tc 3D", timecode_out, 8'h3D);
        chk("C type fct", last_type_data, T_FCT);
        ticks(14);
        chk("C tc parity 3D", last_timein_control_flag_tx, 1);
        chk("C rearmed", state_tx_data, S_TIME);
        chk("C tc 55", timecode_out, 8'h55);
        ticks(14);
        chk("C tc parity 55", last_timein_control_flag_tx, 0);
        chk("C data after tc", state_tx_data, S_DATA);
        chk("C data word", tx_data_out, 9'h011);
        chk("C credit 7", credit, 7);

        // Link drop mid data character.
        do_reset();
        send_data_tx = 1'b1;
        fct_in();
        write_word(9'h0A5);
        ticks(8);
        chk("D data start", state_tx_data, S_DATA);
        write_word(9'h0B0);
        tick_in(8'h12);
        ticks(5);
        chk("D bit 5", bit_index, 5);
        tx_link_enable = 1'b0;
        step();
        chk("D state start", state_tx_data, S_START);
        chk("D credit 0", credit, 0);
        chk("D txready 0", txready, 0);
        chk("D bit 0", bit_index, 0);
        chk("D data cleared", tx_data_out, 0);
        chk("D slot zero", global_counter_transfer_data, 0);
        tx_link_enable = 1'b1;
        step();
        chk("D restart null", state_tx_data, S_NULL);
        chk("D hold cleared", txready, 1);
        ticks(8);
        chk("D pending cleared", state_tx_data, S_NULLC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
